// File: rtl/freq_meter_ctrl_if.sv
// Signal bundle between freq_meter_ctrl and its surroundings: pin input, BCD counter link,
// and result readout. The controller uses the slave modport.
interface freq_meter_ctrl_if;
   logic        start;
   logic        stop;
   logic        cont_mode;
   logic        sig_in;
   logic [15:0] bcd;
   logic        cnt_en;
   logic        cnt_load;
   logic [15:0] cnt_d;
   logic [15:0] result;
   logic        result_valid;
   logic        overflow;
   logic        busy;

   modport master (
      output start, stop, cont_mode, sig_in, bcd,
      input  cnt_en, cnt_load, cnt_d, result, result_valid, overflow, busy
   );

   modport slave (
      input  start, stop, cont_mode, sig_in, bcd,
      output cnt_en, cnt_load, cnt_d, result, result_valid, overflow, busy
   );
endinterface

// File: rtl/freq_meter_ctrl.sv
// Frequency/event meter sequencer driving an external 4-digit BCD counter.
// Build option RESULT_SAT_EN: an overflowed window latches 16'h9999 instead of the wrapped count.
module freq_meter_ctrl #(
   parameter int unsigned GATE_CYCLES = 50000000,
   parameter int unsigned HOLD_CYCLES = 25000000,
   parameter int unsigned TW          = 26
) (
   input logic              clk,
   input logic              reset_n,
   freq_meter_ctrl_if.slave io_bus
);

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StClear  = 3'd1;
   localparam logic [2:0] StGate   = 3'd2;
   localparam logic [2:0] StSettle = 3'd3;
   localparam logic [2:0] StLatch  = 3'd4;
   localparam logic [2:0] StHold   = 3'd5;

   localparam logic [TW-1:0] GateLast = TW'(GATE_CYCLES - 1);
   localparam logic [TW-1:0] HoldLast = TW'(HOLD_CYCLES - 1);

   logic [2:0]    r_state;
   logic [2:0]    w_state_nxt;
   logic [TW-1:0] r_timer;
   logic [TW-1:0] w_timer_nxt;
   logic          r_sync1;
   logic          r_sync2;
   logic          r_sync3;
   logic          r_rise;
   logic          r_ovf;
   logic          r_overflow;
   logic          r_valid;
   logic [15:0]   r_result;
   logic [15:0]   w_latch_val;
   logic          w_latch;
   logic          w_cnt_en;

   assign w_cnt_en = (r_state == StGate) & r_rise;

`ifdef RESULT_SAT_EN
   assign w_latch_val = r_ovf ? 16'h9999 : io_bus.bcd;
`else
   assign w_latch_val = io_bus.bcd;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_latch     = 1'b0;
      if (io_bus.stop) begin
         w_state_nxt = StIdle;
         w_timer_nxt = '0;
      end else begin
         case (r_state)
            StIdle: begin
               if (io_bus.start) w_state_nxt = StClear;
            end
            StClear: begin
               w_timer_nxt = '0;
               w_state_nxt = StGate;
            end
            StGate: begin
               if (r_timer == GateLast) begin
                  w_timer_nxt = '0;
                  w_state_nxt = StSettle;
               end else begin
                  w_timer_nxt = r_timer + 1'b1;
               end
            end
            StSettle: w_state_nxt = StLatch;
            StLatch: begin
               w_latch     = 1'b1;
               w_timer_nxt = '0;
               w_state_nxt = StHold;
            end
            StHold: begin
               if (r_timer == HoldLast) begin
                  w_timer_nxt = '0;
                  w_state_nxt = io_bus.cont_mode ? StClear : StIdle;
               end else begin
                  w_timer_nxt = r_timer + 1'b1;
               end
            end
            default: w_state_nxt = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= StIdle;
         r_timer <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
      end
   end

   // Two-flop synchronizer plus a third stage so the rise pulse is one clean registered cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
         r_rise  <= 1'b0;
      end else begin
         r_sync1 <= io_bus.sig_in;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
         r_rise  <= r_sync2 & ~r_sync3;
      end
   end

   // Sticky until the next CLEAR; the counter itself wraps to 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ovf <= 1'b0;
      end else if (r_state == StClear) begin
         r_ovf <= 1'b0;
      end else if (w_cnt_en && (io_bus.bcd == 16'h9999)) begin
         r_ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_result   <= 16'h0000;
         r_overflow <= 1'b0;
         r_valid    <= 1'b0;
      end else begin
         r_valid <= w_latch;
         if (w_latch) begin
            r_result   <= w_latch_val;
            r_overflow <= r_ovf;
         end
      end
   end

   assign io_bus.cnt_en       = w_cnt_en;
   assign io_bus.cnt_load     = (r_state == StClear);
   assign io_bus.cnt_d        = 16'h0000;
   assign io_bus.result       = r_result;
   assign io_bus.result_valid = r_valid;
   assign io_bus.overflow     = r_overflow;
   assign io_bus.busy         = (r_state != StIdle);

endmodule
